climate_alarm_ctrl: RTL and testbench

Scheduler and controller for the temperature/humidity alarm datapath.
- Generates a periodic sample tick and qualifies the raw 5-bit temperature bus and the 1-bit humidity flag over QUAL_N consecutive equal samples.
- Runs a hysteretic NORMAL/WARN/ALARM state machine with a latched, acknowledged alarm.
- Drives the registered alarm, warning and 4-bit status code consumed by the seven-segment display block.

---
 rtl/climate_pkg.sv | 21 ++
 rtl/climate_alarm_ctrl_sample_qualifier.sv | 68 ++++++
 rtl/climate_alarm_ctrl.sv | 148 ++++++++++++++
 tb/tb_climate_alarm_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/climate_pkg.sv
// Shared types and constants for the climate alarm controller.
// Contents: FSM state enum with its 2-bit codes, default thresholds, temperature width.
package climate_pkg;

  localparam int unsigned TempWidth = 5;

  localparam int unsigned DefTickDiv = 50000;
  localparam int unsigned DefQualN   = 3;
  localparam int unsigned DefTWarn   = 26;
  localparam int unsigned DefTAlarm  = 29;
  localparam int unsigned DefHyst    = 2;

  // Enumerator values double as the status[1:0] state code.
  typedef enum logic [1:0] {
    StInit   = 2'd0,
    StNormal = 2'd1,
    StWarn   = 2'd2,
    StAlarm  = 2'd3
  } state_e;

endpackage

// File: rtl/climate_alarm_ctrl_sample_qualifier.sv
// sample_qualifier: accepts a new value only after QUAL_N consecutive equal samples.
// Ports:
//   clk_i, clr_i   clock, synchronous active-high clear
//   tick_i         sample strobe; the qualifier only moves on tick cycles
//   sample_i       raw sample
//   qual_o         qualified (registered) value
//   upd_o          one-cycle pulse in the cycle after qual_o was (re)loaded
module sample_qualifier #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned QUAL_N = 3
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic [WIDTH-1:0] qual_o,
  output logic             upd_o
);

  localparam int unsigned CntW = (QUAL_N > 2) ? $clog2(QUAL_N) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(QUAL_N - 1);
  localparam logic [CntW-1:0] CntArm = CntW'(QUAL_N - 2);

  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] qual_q, qual_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             upd_q, upd_d;

  always_comb begin
    last_d = last_q;
    qual_d = qual_q;
    cnt_d  = cnt_q;
    upd_d  = 1'b0;
    if (tick_i) begin
      if (sample_i == last_q) begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
        // Load only on the tick that completes the run; a saturated run stays quiet.
        if (cnt_q == CntArm) begin
          qual_d = sample_i;
          upd_d  = 1'b1;
        end
      end else begin
        last_d = sample_i;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      last_q <= '0;
      qual_q <= '0;
      cnt_q  <= '0;
      upd_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      qual_q <= qual_d;
      cnt_q  <= cnt_d;
      upd_q  <= upd_d;
    end
  end

  assign qual_o = qual_q;
  assign upd_o  = upd_q;

endmodule

// File: rtl/climate_alarm_ctrl.sv
// climate_alarm_ctrl: sample-tick prescaler, temperature/humidity qualification and the
// NORMAL/WARN/ALARM hysteretic state machine with a latched, acknowledged alarm.
// Ports:
//   clock, clr     clock, synchronous active-high reset
//   temp_in        raw 5-bit temperature code
//   hum_in         raw humidity-high flag
//   ack            alarm acknowledge (level, sampled every clock)
//   sample_tick    one-cycle pulse per sample period
//   temp_q, hum_q  qualified temperature and humidity
//   warning, alarm state == WARN / state == ALARM
//   status         {hum_q, 1'b0, state code}
// Build option: define ALARM_AUTOCLR_EN to let ALARM clear to WARN on a cool update
// without an acknowledge.
module climate_alarm_ctrl
  import climate_pkg::*;
#(
  parameter int unsigned TICK_DIV = DefTickDiv,
  parameter int unsigned QUAL_N   = DefQualN,
  parameter int unsigned T_WARN   = DefTWarn,
  parameter int unsigned T_ALARM  = DefTAlarm,
  parameter int unsigned HYST     = DefHyst
) (
  input  logic                 clock,
  input  logic                 clr,
  input  logic [TempWidth-1:0] temp_in,
  input  logic                 hum_in,
  input  logic                 ack,
  output logic                 sample_tick,
  output logic [TempWidth-1:0] temp_q,
  output logic                 hum_q,
  output logic                 warning,
  output logic                 alarm,
  output logic [3:0]           status
);

  localparam int unsigned PrescW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

  localparam logic [5:0] TWarnHi  = 6'(T_WARN);
  localparam logic [5:0] TAlarmHi = 6'(T_ALARM);
  localparam logic [5:0] TWarnLo  = 6'(T_WARN - HYST);
  localparam logic [5:0] TAlarmLo = 6'(T_ALARM - HYST);

  logic [PrescW-1:0] presc_q, presc_d;
  logic              tick_q;
  state_e            state_q, state_d;
  logic              warning_q, alarm_q;
  logic [3:0]        status_q;

  logic temp_upd, hum_upd, upd;
  logic [5:0] temp_ext;

  // Prescaler; the tick flop is loaded from the next count so it is high while count == max.
  always_comb begin
    presc_d = (presc_q == PrescMax) ? '0 : presc_q + PrescW'(1);
  end

  sample_qualifier #(
    .WIDTH  (TempWidth),
    .QUAL_N (QUAL_N)
  ) u_temp_qual (
    .clk_i    (clock),
    .clr_i    (clr),
    .tick_i   (tick_q),
    .sample_i (temp_in),
    .qual_o   (temp_q),
    .upd_o    (temp_upd)
  );

  sample_qualifier #(
    .WIDTH  (1),
    .QUAL_N (QUAL_N)
  ) u_hum_qual (
    .clk_i    (clock),
    .clr_i    (clr),
    .tick_i   (tick_q),
    .sample_i (hum_in),
    .qual_o   (hum_q),
    .upd_o    (hum_upd)
  );

  assign upd      = temp_upd | hum_upd;
  assign temp_ext = {1'b0, temp_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      StInit, StNormal: begin
        if (upd) begin
          if (temp_ext >= TAlarmHi) begin
            state_d = StAlarm;
          end else if (temp_ext >= TWarnHi || hum_q) begin
            state_d = StWarn;
          end else begin
            state_d = StNormal;
          end
        end
      end
      StWarn: begin
        if (upd) begin
          if (temp_ext >= TAlarmHi) begin
            state_d = StAlarm;
          end else if (temp_ext < TWarnLo && !hum_q) begin
            state_d = StNormal;
          end
        end
      end
      StAlarm: begin
        // temp_q is the registered value, so an ack coinciding with a tick edge
        // is judged against the pre-update temperature.
`ifdef ALARM_AUTOCLR_EN
        if ((ack || upd) && temp_ext < TAlarmLo) begin
          state_d = StWarn;
        end
`else
        if (ack && temp_ext < TAlarmLo) begin
          state_d = StWarn;
        end
`endif
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      state_q   <= StInit;
      warning_q <= 1'b0;
      alarm_q   <= 1'b0;
      status_q  <= '0;
    end else begin
      presc_q   <= presc_d;
      tick_q    <= (presc_d == PrescMax);
      state_q   <= state_d;
      warning_q <= (state_d == StWarn);
      alarm_q   <= (state_d == StAlarm);
      status_q  <= {hum_q, 1'b0, state_d};
    end
  end

  assign sample_tick = tick_q;
  assign warning     = warning_q;
  assign alarm       = alarm_q;
  assign status      = status_q;

endmodule

// File: tb/tb_climate_alarm_ctrl.sv
// Bench for climate_alarm_ctrl with TICK_DIV = 4, QUAL_N = 3 and default thresholds.
// Directed table rows plus hand sequences, with a history-based reference model
// compared against the DUT on every clock.
module tb_climate_alarm_ctrl;

  localparam int TD = 4;
  localparam int QN = 3;
  localparam int TW = 26;
  localparam int TA = 29;
  localparam int HY = 2;
`ifdef ALARM_AUTOCLR_EN
  localparam bit AutoClr = 1'b1;
`else
  localparam bit AutoClr = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       clr = 1'b1;
  logic [4:0] temp_in = '0;
  logic       hum_in = 1'b0;
  logic       ack = 1'b0;
  logic       sample_tick;
  logic [4:0] temp_q;
  logic       hum_q;
  logic       warning;
  logic       alarm;
  logic [3:0] status;

  climate_alarm_ctrl #(
    .TICK_DIV (TD),
    .QUAL_N   (QN),
    .T_WARN   (TW),
    .T_ALARM  (TA),
    .HYST     (HY)
  ) dut (
    .clock       (clock),
    .clr         (clr),
    .temp_in     (temp_in),
    .hum_in      (hum_in),
    .ack         (ack),
    .sample_tick (sample_tick),
    .temp_q      (temp_q),
    .hum_q       (hum_q),
    .warning     (warning),
    .alarm       (alarm),
    .status      (status)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: state 0..3 = INIT/NORMAL/WARN/ALARM.
  int m_k, m_tq, m_hq, m_state, m_status;
  bit m_tick, m_upd;
  int th[$];
  int hh[$];

  // True when the newest QN tick samples are equal and the run is exactly QN long.
  function automatic bit run_done(input int q[$]);
    int n;
    bit ok;
    n = q.size();
    if (n < QN) return 1'b0;
    ok = 1'b1;
    for (int i = 1; i < QN; i++) if (q[n-1-i] != q[n-1]) ok = 1'b0;
    if (n > QN && q[n-1-QN] == q[n-1]) ok = 1'b0;
    return ok;
  endfunction

  task automatic model_reset();
    m_k = 0; m_tick = 0; m_tq = 0; m_hq = 0; m_state = 0; m_status = 0; m_upd = 0;
    th.delete(); hh.delete();
    th.push_back(0); hh.push_back(0);  // reset contents count as one prior sample
  endtask

  task automatic model_edge();
    int ns;
    bit nu;
    if (clr) begin
      model_reset();
      return;
    end
    ns = m_state;
    if (m_state == 3) begin
      if ((ack || (AutoClr && m_upd)) && m_tq < TA - HY) ns = 2;
    end else if (m_upd) begin
      if (m_tq >= TA) ns = 3;
      else if (m_state == 2) ns = (m_tq < TW - HY && !m_hq) ? 1 : 2;
      else ns = (m_tq >= TW || m_hq) ? 2 : 1;
    end
    m_status = (m_hq << 3) | ns;
    m_state = ns;
    nu = 1'b0;
    if (m_tick) begin
      th.push_back(int'(temp_in));
      hh.push_back(int'(hum_in));
      if (th.size() > QN + 1) void'(th.pop_front());
      if (hh.size() > QN + 1) void'(hh.pop_front());
      if (run_done(th)) begin m_tq = th[th.size()-1]; nu = 1'b1; end
      if (run_done(hh)) begin m_hq = hh[hh.size()-1]; nu = 1'b1; end
    end
    m_upd = nu;
    m_k++;
    m_tick = ((m_k % TD) == TD - 1);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: model advances on the edge, DUT sampled 1 time unit later.
  task automatic step();
    logic [13:0] got, exp;
    @(posedge clock);
    model_edge();
    #1;
    got = {sample_tick, temp_q, hum_q, warning, alarm, status};
    exp = {m_tick, 5'(m_tq), 1'(m_hq), m_state == 2, m_state == 3, 4'(m_status)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model_cycle @%0t: dut tick=%0b tq=%0d hq=%0b w=%0b a=%0b st=%h, model tick=%0b tq=%0d hq=%0d w=%0b a=%0b st=%h",
               $time, sample_tick, temp_q, hum_q, warning, alarm, status,
               m_tick, m_tq, m_hq, m_state == 2, m_state == 3, m_status[3:0]);
    end
  endtask

  typedef struct {
    int temp;
    int hum;
    int ack;
    int periods;
    int tq;
    int hq;
    int warn;
    int alm;
    int st;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{20, 0, 0, 4, 20, 0, 0, 0, 1};   // qualify from reset
    vecs[1]  = '{30, 0, 0, 2, 20, 0, 0, 0, 1};   // 2-tick glitch rejected
    vecs[2]  = '{20, 0, 0, 4, 20, 0, 0, 0, 1};
    vecs[3]  = '{27, 0, 0, 4, 27, 0, 1, 0, 2};   // warn
    vecs[4]  = '{25, 0, 0, 4, 25, 0, 1, 0, 2};   // inside hysteresis band
    vecs[5]  = '{23, 0, 0, 4, 23, 0, 0, 0, 1};   // below low threshold
    vecs[6]  = '{30, 0, 0, 4, 30, 0, 0, 1, 3};   // alarm
    vecs[7]  = '{30, 0, 1, 4, 30, 0, 0, 1, 3};   // ack while hot ignored
`ifdef ALARM_AUTOCLR_EN
    vecs[8]  = '{26, 0, 0, 4, 26, 0, 1, 0, 2};   // auto-clear on cool update
`else
    vecs[8]  = '{26, 0, 0, 4, 26, 0, 0, 1, 3};   // latched without ack
`endif
    vecs[9]  = '{26, 0, 1, 1, 26, 0, 1, 0, 2};   // ack releases to WARN
    vecs[10] = '{20, 1, 0, 4, 20, 1, 1, 0, 10};  // humidity warning
    vecs[11] = '{20, 0, 0, 4, 20, 0, 0, 0, 1};

    model_reset();
    clr = 1'b1;
    step();
    step();
    chk("reset_status", status, 0);
    chk("reset_alarm", alarm, 0);
    chk("reset_tick", sample_tick, 0);
    chk("reset_temp_q", temp_q, 0);
    clr = 1'b0;

    foreach (vecs[i]) begin
      temp_in = 5'(vecs[i].temp);
      hum_in  = 1'(vecs[i].hum);
      ack     = 1'(vecs[i].ack);
      for (int c = 0; c < vecs[i].periods * TD; c++) begin
        step();
        if (i == 0) begin
          if (c == 1)  chk("pre_first_tick", sample_tick, 0);
          if (c == 2)  chk("first_tick", sample_tick, 1);
          if (c == 10) chk("temp_q_before_3rd_tick", temp_q, 0);
          if (c == 11) chk("temp_q_after_3rd_tick", temp_q, 20);
          if (c == 12) chk("status_after_qual", status, 1);
        end
      end
      chk($sformatf("row%0d_temp_q", i), temp_q, vecs[i].tq);
      chk($sformatf("row%0d_hum_q", i), hum_q, vecs[i].hq);
      chk($sformatf("row%0d_warning", i), warning, vecs[i].warn);
      chk($sformatf("row%0d_alarm", i), alarm, vecs[i].alm);
      chk($sformatf("row%0d_status", i), status, vecs[i].st);
    end
    ack = 1'b0;

    // Reset while in ALARM.
    temp_in = 5'd30;
    hum_in  = 1'b1;
    for (int c = 0; c < 4 * TD; c++) step();
    chk("pre_clr_alarm", alarm, 1);
    chk("pre_clr_status", status, 11);
    clr = 1'b1;
    step();
    chk("clr_alarm", alarm, 0);
    chk("clr_warning", warning, 0);
    chk("clr_status", status, 0);
    chk("clr_temp_q", temp_q, 0);
    chk("clr_hum_q", hum_q, 0);
    chk("clr_tick", sample_tick, 0);
    clr = 1'b0;

    // Randomised stretch, concentrated around the thresholds.
    for (int r = 0; r < 80; r++) begin
      temp_in = 5'($urandom_range(18, 31));
      hum_in  = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < int'($urandom_range(2, 14)); c++) begin
        ack = ($urandom_range(0, 4) == 0);
        clr = ($urandom_range(0, 199) == 0);
        step();
      end
    end
    clr = 1'b0;
    ack = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
